// File: rtl/axil_modport_slave_mem.sv
// AXI4-Lite slave word memory: single-beat reads and byte-strobed writes,
// one outstanding transaction per direction.
module axil_modport_slave_mem #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [1:0]            RESP_OKAY  = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    // Unsigned subtraction wraps addresses below the base to large offsets.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    assign awready = !rst && !aw_held && !bvalid;
    assign wready  = !rst && !w_held && !bvalid;
    assign arready = !rst && !rvalid;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A write commits once both halves are present, whether held or arriving now.
    assign commit  = !rst && (aw_held || aw_hs) && (w_held || w_hs) && !bvalid;
    assign wr_addr = aw_held ? aw_addr_q : awaddr;
    assign wr_data = w_held ? w_data_q : wdata;
    assign wr_strb = w_held ? w_strb_q : wstrb;
    assign wr_ok   = in_range(wr_addr);
    assign rd_ok   = in_range(araddr);
    assign wr_idx  = word_idx(wr_addr);
    assign rd_idx  = word_idx(araddr);

    // Memory array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (commit && wr_ok) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read path: nonblocking read of mem gives read-before-write on a shared edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_ok ? mem[rd_idx] : '0;
            rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_modport_slave_mem.sv
// Bench for axil_modport_slave_mem: transaction-level memory model checked
// every cycle, plus directed transactions with literal expected values.
module tb_axil_modport_slave_mem;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int vectors = 0;
    int errors  = 0;

    axil_modport_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake at %0t", nm, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [int];
    bit          armed = 0;
    bit          rst_applied = 0;
    bit          m_aw_pend, m_w_pend, m_b_out, m_r_out, m_r_known;
    logic [31:0] m_aw_addr, m_w_data, m_r_data;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;

    function automatic bit addr_ok(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return off >= 0 && off < longint'(DEPTH) * 4;
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic model_clear();
        m_aw_pend = 0; m_w_pend = 0; m_b_out = 0; m_r_out = 0;
        m_r_data = '0; m_r_resp = 2'b00; m_b_resp = 2'b00; m_r_known = 1;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int          idx;
        logic [31:0] w;
        idx = addr_idx(a);
        if (mm.exists(idx) || s == 4'hF) begin
            w = mm.exists(idx) ? mm[idx] : 32'h0;
            for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
            mm[idx] = w;
        end
    endtask

    // Compare outputs, then advance the model by the upcoming edge.
    always @(negedge clk) begin
        if (armed) begin
            bit old_b;
            if (rst_applied) begin
                check("rst_bvalid", 32'(bvalid), 32'd0);
                check("rst_rvalid", 32'(rvalid), 32'd0);
                check("rst_bresp", 32'(bresp), 32'd0);
                check("rst_rresp", 32'(rresp), 32'd0);
                check("rst_rdata", rdata, 32'd0);
            end else begin
                check("bvalid", 32'(bvalid), 32'(m_b_out));
                if (m_b_out) check("bresp", 32'(bresp), 32'(m_b_resp));
                check("rvalid", 32'(rvalid), 32'(m_r_out));
                if (m_r_out) check("rresp", 32'(rresp), 32'(m_r_resp));
                if (m_r_known) check("rdata", rdata, m_r_data);
            end
            check("awready", 32'(awready), 32'(!rst && !m_aw_pend && !m_b_out));
            check("wready", 32'(wready), 32'(!rst && !m_w_pend && !m_b_out));
            check("arready", 32'(arready), 32'(!rst && !m_r_out));

            if (rst) begin
                model_clear();
            end else begin
                if (m_r_out && rready) m_r_out = 0;
                if (arvalid && arready) begin
                    m_r_out = 1;
                    if (addr_ok(araddr)) begin
                        m_r_resp  = 2'b00;
                        m_r_known = mm.exists(addr_idx(araddr));
                        m_r_data  = m_r_known ? mm[addr_idx(araddr)] : 32'h0;
                    end else begin
                        m_r_resp  = 2'b10;
                        m_r_known = 1;
                        m_r_data  = 32'h0;
                    end
                end
                old_b = m_b_out;
                if (m_b_out && bready) m_b_out = 0;
                if (awvalid && awready) begin m_aw_pend = 1; m_aw_addr = awaddr; end
                if (wvalid && wready) begin m_w_pend = 1; m_w_data = wdata; m_w_strb = wstrb; end
                if (m_aw_pend && m_w_pend && !old_b) begin
                    if (addr_ok(m_aw_addr)) begin
                        model_write(m_aw_addr, m_w_data, m_w_strb);
                        m_b_resp = 2'b00;
                    end else begin
                        m_b_resp = 2'b10;
                    end
                    m_b_out = 1; m_aw_pend = 0; m_w_pend = 0;
                end
            end
        end else if (rst) begin
            armed = 1;
            model_clear();
        end
        rst_applied = rst;
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_aw(input logic [31:0] a, input int lag);
        bit ok = 0;
        repeat (lag) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout("aw_wait");
        @(posedge clk); #1; awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        wdata = d; wstrb = s; wvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
        end
        if (!ok) timeout("w_wait");
        @(posedge clk); #1; wvalid = 0;
    endtask

    task automatic get_b(input logic [1:0] exp, input int hold, input string nm);
        bit ok = 0;
        bready = (hold == 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; break; end
        end
        if (!ok) begin timeout(nm); bready = 0; return; end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            @(posedge clk); #1; bready = 1;
            @(negedge clk);
        end
        check(nm, 32'(bresp), 32'(exp));
        @(posedge clk); #1; bready = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_lag, input logic [1:0] exp, input int hold, input string nm);
        fork
            send_aw(a, aw_lag);
            send_w(d, s);
        join
        get_b(exp, hold, nm);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int hold, input string nm);
        bit ok = 0;
        araddr = a; arvalid = 1; rready = (hold == 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) begin timeout(nm); arvalid = 0; rready = 0; return; end
        @(posedge clk); #1; arvalid = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; break; end
        end
        if (!ok) begin timeout(nm); rready = 0; return; end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            @(posedge clk); #1; rready = 1;
            @(negedge clk);
        end
        check({nm, "_data"}, rdata, exp_d);
        check({nm, "_resp"}, 32'(rresp), 32'(exp_r));
        @(posedge clk); #1; rready = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_awready", 32'(awready), 32'd0);
        check("reset_wready", 32'(wready), 32'd0);
        check("reset_arready", 32'(arready), 32'd0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("idle_awready", 32'(awready), 32'd1);
        check("idle_wready", 32'(wready), 32'd1);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_bvalid", 32'(bvalid), 32'd0);
        check("idle_rvalid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 2'b00, 0, "wr_simul");
        do_read(32'h10, 32'hDEADBEEF, 2'b00, 0, "rd_simul");
        do_read(32'h13, 32'hDEADBEEF, 2'b00, 0, "rd_lowbits");

        do_write(32'h14, 32'h11223344, 4'hF, 3, 2'b00, 0, "wr_wfirst");
        do_write(32'h14, 32'h0000AA00, 4'b0010, 0, 2'b00, 0, "wr_strb");
        do_read(32'h14, 32'h1122AA44, 2'b00, 0, "rd_strb");

        do_write(32'h18, 32'hA5A55A5A, 4'hF, 0, 2'b00, 5, "wr_bp");
        do_read(32'h18, 32'hA5A55A5A, 2'b00, 5, "rd_bp");

        do_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 2'b00, 0, "wr_w0");
        do_write(32'hFFC, 32'h0BADC0DE, 4'hF, 0, 2'b00, 0, "wr_last");
        do_write(BASE + DEPTH * 4, 32'hFFFFFFFF, 4'hF, 0, 2'b10, 0, "wr_oor");
        do_read(BASE + DEPTH * 4, 32'h0, 2'b10, 0, "rd_oor");
        do_read(32'h0, 32'hCAFEF00D, 2'b00, 0, "rd_w0");
        do_read(32'hFFC, 32'h0BADC0DE, 2'b00, 0, "rd_last");

        do_write(32'h20, 32'h1, 4'hF, 0, 2'b00, 0, "wr_pre");
        fork
            do_write(32'h20, 32'h5, 4'hF, 0, 2'b00, 0, "wr_same");
            do_read(32'h20, 32'h1, 2'b00, 0, "rd_same");
        join
        do_read(32'h20, 32'h5, 2'b00, 0, "rd_after");

        do_write(32'h30, 32'h777, 4'hF, 0, 2'b00, 0, "wr_pre30");
        send_aw(32'h30, 0);
        rst = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", 32'(bvalid), 32'd0);
        end
        @(posedge clk); #1;
        do_read(32'h30, 32'h777, 2'b00, 0, "rd_post_rst");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

endmodule
